// File: rtl/seq_array_multiplier.sv
// Sequential shift-add multiplier: retires one multiplier bit per clock, signed or unsigned,
// with a valid/ready handshake on both the operand and the product side.
module seq_array_multiplier #(
  parameter int M = 4,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [M-1:0]   a,
  input  logic [N-1:0]   x,
  input  logic           signed_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M+N-1:0] product
);

  localparam int W  = M + N;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [M-1:0]    a_q;
  logic [N-1:0]    x_q;
  logic            sgn_q;
  logic [W-1:0]    acc, acc_next, a_ext, pp;
  logic [CW-1:0]   cnt;
  logic            accept, handshake, last_bit;

  assign in_ready  = (state == IDLE) & rst_n;
  assign accept    = in_valid & in_ready;
  assign handshake = out_valid & out_ready;
  assign last_bit  = (cnt == LAST);

  // NOTE: every signal written here gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = RUN;
      RUN:     if (last_bit)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // In signed mode the top multiplier bit carries weight -2^(N-1), so its row is subtracted.
  always_comb begin
    a_ext    = {{N{sgn_q & a_q[M-1]}}, a_q};
    pp       = x_q[cnt] ? (a_ext << cnt) : '0;
    acc_next = (sgn_q && last_bit) ? (acc - pp) : (acc + pp);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: the operand registers are not reset; they are always loaded on accept before
  // they are read, so resetting them would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      product   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= a;
        x_q   <= x;
        sgn_q <= signed_mode;
        acc   <= '0;
        cnt   <= '0;
      end
      if (state == RUN) begin
        acc <= acc_next;
        cnt <= cnt + CW'(1);
        if (last_bit) begin
          out_valid <= 1'b1;
          product   <= acc_next;
        end
      end
      if (handshake) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Self-checking bench: directed handshake/latency/reset cases on a 4x4 instance and
// randomized traffic on 8x3 and 3x1 instances against a plain-arithmetic product model.
module tb_seq_array_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Product of the operands interpreted per mode, wrapped to m+n bits.
  function automatic logic [63:0] ref_mul(input longint a, input longint x,
                                          input int m, input int n, input bit s);
    longint sa, sx, p;
    sa = a;
    sx = x;
    if (s && a[m-1]) sa = a - (longint'(1) << m);
    if (s && x[n-1]) sx = x - (longint'(1) << n);
    p = sa * sx;
    return 64'(p) & ((64'd1 << (m + n)) - 64'd1);
  endfunction

  // 4x4 instance for directed tests
  logic       rst4_n, iv4, ir4, s4, ov4, or4;
  logic [3:0] a4, x4;
  logic [7:0] p4;

  seq_array_multiplier #(.M(4), .N(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .x(x4),
    .signed_mode(s4), .out_valid(ov4), .out_ready(or4), .product(p4));

  // 8x3 and 3x1 instances for random traffic
  logic        rstr_n;
  logic        b_iv, b_ir, b_s, b_ov, b_or;
  logic [7:0]  b_a;
  logic [2:0]  b_x;
  logic [10:0] b_p;
  logic        c_iv, c_ir, c_s, c_ov, c_or;
  logic [2:0]  c_a;
  logic [0:0]  c_x;
  logic [3:0]  c_p;

  seq_array_multiplier #(.M(8), .N(3)) dut_b (
    .clk(clk), .rst_n(rstr_n), .in_valid(b_iv), .in_ready(b_ir), .a(b_a), .x(b_x),
    .signed_mode(b_s), .out_valid(b_ov), .out_ready(b_or), .product(b_p));

  seq_array_multiplier #(.M(3), .N(1)) dut_c (
    .clk(clk), .rst_n(rstr_n), .in_valid(c_iv), .in_ready(c_ir), .a(c_a), .x(c_x),
    .signed_mode(c_s), .out_valid(c_ov), .out_ready(c_or), .product(c_p));

  logic [63:0] qb[$];
  logic [63:0] qc[$];

  // One operation on the 4x4 instance: accept, wait for the product, optional backpressure.
  task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] x, input bit s,
                      input int hold, input bit churn, input logic [7:0] exp);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(ir4), 64'd1);
    iv4 = 1'b1; a4 = a; x4 = x; s4 = s; or4 = 1'b0;
    @(negedge clk);
    if (!churn) iv4 = 1'b0;
    lat = 0;
    while (!ov4 && lat < 12) begin
      if (churn) begin a4 = 4'($urandom); x4 = 4'($urandom); s4 = 1'($urandom); end
      check({tag, "_busy_in_ready"}, 64'(ir4), 64'd0);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd4);
    check({tag, "_product"}, 64'(p4), 64'(exp));
    repeat (hold) begin
      if (churn) begin a4 = 4'($urandom); x4 = 4'($urandom); end
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(ov4), 64'd1);
      check({tag, "_hold_product"}, 64'(p4), 64'(exp));
      check({tag, "_hold_in_ready"}, 64'(ir4), 64'd0);
    end
    iv4 = 1'b0; or4 = 1'b1;
    @(negedge clk);
    or4 = 1'b0;
    check({tag, "_post_valid"}, 64'(ov4), 64'd0);
    check({tag, "_post_in_ready"}, 64'(ir4), 64'd1);
  endtask

  initial begin
    int b_acc = 0, b_done = 0, c_acc = 0, c_done = 0;
    rst4_n = 1'b0; rstr_n = 1'b0;
    iv4 = 0; a4 = 0; x4 = 0; s4 = 0; or4 = 0;
    b_iv = 0; b_a = 0; b_x = 0; b_s = 0; b_or = 0;
    c_iv = 0; c_a = 0; c_x = 0; c_s = 0; c_or = 0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(ov4), 64'd0);
    check("rst_product", 64'(p4), 64'd0);
    check("rst_in_ready", 64'(ir4), 64'd0);
    rst4_n = 1'b1; rstr_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 64'(ir4), 64'd1);

    // out_ready with nothing pending is ignored
    or4 = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_out_ready_ignored", 64'(ov4), 64'd0);
    or4 = 1'b0;

    run4("u15x15", 4'hF, 4'hF, 1'b0, 0, 1'b0, 8'hE1);
    run4("s_m8xm8", 4'h8, 4'h8, 1'b1, 0, 1'b0, 8'h40);
    run4("s_m1x7", 4'hF, 4'h7, 1'b1, 0, 1'b0, 8'hF9);
    run4("u15x7", 4'hF, 4'h7, 1'b0, 0, 1'b0, 8'h69);
    run4("backpressure", 4'h5, 4'h6, 1'b1, 6, 1'b0, 8'h1E);
    run4("churn", 4'h3, 4'hB, 1'b1, 2, 1'b1, 8'hF1);

    // Reset while RUN at cnt==2: operation dropped
    @(negedge clk);
    iv4 = 1'b1; a4 = 4'h7; x4 = 4'h9; s4 = 1'b0;
    @(negedge clk);
    iv4 = 1'b0;
    repeat (2) @(negedge clk);
    rst4_n = 1'b0;
    @(negedge clk);
    rst4_n = 1'b1;
    check("midrst_out_valid", 64'(ov4), 64'd0);
    check("midrst_product", 64'(p4), 64'd0);
    repeat (5) @(negedge clk);
    check("midrst_no_valid", 64'(ov4), 64'd0);
    run4("after_rst", 4'h6, 4'hD, 1'b0, 1, 1'b0, 8'h4E);

    // Randomized traffic on both other instances
    fork
      begin
        int cyc = 0;
        while (b_done < 1000 && cyc < 40000) begin
          @(negedge clk);
          cyc++;
          b_a = 8'($urandom); b_x = 3'($urandom);
          b_s = (b_acc >= 500);
          b_iv = (b_acc < 1000) && ($urandom_range(0, 3) != 0);
          b_or = ($urandom_range(0, 2) != 0);
          if (b_iv && b_ir) begin
            qb.push_back(ref_mul(longint'(b_a), longint'(b_x), 8, 3, b_s));
            b_acc++;
          end
          if (b_ov && b_or) begin
            if (qb.size() == 0) check("b_unexpected_product", 64'd1, 64'd0);
            else                check("b_product", 64'(b_p), qb.pop_front());
            b_done++;
          end
        end
        b_iv = 1'b0;
        check("b_ops_completed", 64'(b_done), 64'd1000);
      end
      begin
        int cyc = 0;
        while (c_done < 1000 && cyc < 40000) begin
          @(negedge clk);
          cyc++;
          c_a = 3'($urandom); c_x = 1'($urandom);
          c_s = (c_acc >= 500);
          c_iv = (c_acc < 1000) && ($urandom_range(0, 3) != 0);
          c_or = ($urandom_range(0, 2) != 0);
          if (c_iv && c_ir) begin
            qc.push_back(ref_mul(longint'(c_a), longint'(c_x), 3, 1, c_s));
            c_acc++;
          end
          if (c_ov && c_or) begin
            if (qc.size() == 0) check("c_unexpected_product", 64'd1, 64'd0);
            else                check("c_product", 64'(c_p), qc.pop_front());
            c_done++;
          end
        end
        c_iv = 1'b0;
        check("c_ops_completed", 64'(c_done), 64'd1000);
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
